ciphertext_word_packer: RTL

- Sits directly downstream of the three-stage Caesar cipher stage and consumes its registered outputs: ciphertext_char, flag_ciphertext_ready, err_invalid_key_shift_num and err_invalid_ptxt_char.
- Packs accepted ciphertext characters into 32-bit words, four chars per word, first char in the LSB.
- Buffers completed words in a small show-ahead FIFO and hands them to a consumer over a valid/ready handshake.
- Keeps saturating error counters and a sticky overflow flag for the message.

---
 rtl/three_stage_caesar_pkg.sv | 12 +
 rtl/cipher_word_fifo.sv | 50 +++++
 rtl/ciphertext_word_packer.sv | 109 ++++++++++
 3 files changed

// File: rtl/three_stage_caesar_pkg.sv
// Shared constants and word type for the ciphertext packing path.
package three_stage_caesar_pkg;

  localparam logic [7:0] NULL_CHAR      = 8'h00;
  localparam int         CHARS_PER_WORD = 4;

  typedef struct packed {
    logic [2:0]  byte_count;
    logic [31:0] data;
  } cipher_word_t;

endpackage

// File: rtl/cipher_word_fifo.sv
// Synchronous show-ahead FIFO of packed ciphertext words.
module cipher_word_fifo
  import three_stage_caesar_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  cipher_word_t push_data,
  input  logic         pop,
  output cipher_word_t head,
  output logic         empty,
  output logic         full,
  output logic [AW:0]  level
);

  // Pointers carry one extra bit so that full and empty are distinguishable.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  cipher_word_t mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (level == '0);
  assign full    = (level == (AW + 1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // When full, a same-edge pop frees the slot the push lands in.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Storage write; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Read/write pointer advance, wrapping naturally modulo 2*DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ciphertext_word_packer.sv
// Packs cipher-stage chars into 32-bit words, buffers them, counts errors.
module ciphertext_word_packer
  import three_stage_caesar_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int COUNT_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    ciphertext_char,
  input  logic                          flag_ciphertext_ready,
  input  logic                          err_invalid_key_shift_num,
  input  logic                          err_invalid_ptxt_char,
  input  logic                          flush,
  input  logic                          word_ready,
  output logic                          word_valid,
  output logic [31:0]                   word_data,
  output logic [2:0]                    word_byte_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [COUNT_W-1:0]            err_key_count,
  output logic [COUNT_W-1:0]            err_char_count,
  output logic                          err_fifo_overflow
);

  logic [31:0]  pack_data;
  logic [2:0]   pack_cnt;
  logic [31:0]  data_next;
  logic [2:0]   cnt_next;
  logic         push_full;
  logic         push_flush;
  logic         push_req;
  logic         pop;
  logic         fifo_push;
  logic         fifo_empty;
  logic         fifo_full;
  cipher_word_t push_word;
  cipher_word_t head;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Accumulator view after this cycle's char; decides full-word or flush push.
  always_comb begin
    data_next = pack_data;
    cnt_next  = pack_cnt;
    if (flag_ciphertext_ready) begin
      for (int i = 0; i < CHARS_PER_WORD; i++) begin
        if (pack_cnt == 3'(i)) data_next[i*8 +: 8] = ciphertext_char;
      end
      cnt_next = pack_cnt + 3'd1;
    end
    push_full            = (cnt_next == 3'(CHARS_PER_WORD));
    push_flush           = flush && (cnt_next != 3'd0) && !push_full;
    push_req             = push_full || push_flush;
    push_word.byte_count = cnt_next;
    push_word.data       = data_next;
  end

  assign pop       = !fifo_empty && word_ready;
  // A word arriving at a full FIFO with no pop is dropped here.
  assign fifo_push = push_req && (!fifo_full || pop);

  // Accumulator: clears whenever a word leaves it, pushed or dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pack_data <= {CHARS_PER_WORD{NULL_CHAR}};
      pack_cnt  <= 3'd0;
    end else if (push_req) begin
      pack_data <= {CHARS_PER_WORD{NULL_CHAR}};
      pack_cnt  <= 3'd0;
    end else begin
      pack_data <= data_next;
      pack_cnt  <= cnt_next;
    end
  end

  // Saturating error counters and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_key_count     <= '0;
      err_char_count    <= '0;
      err_fifo_overflow <= 1'b0;
    end else begin
      if (err_invalid_key_shift_num) err_key_count  <= sat_inc(err_key_count);
      if (err_invalid_ptxt_char)     err_char_count <= sat_inc(err_char_count);
      if (push_req && fifo_full && !pop) err_fifo_overflow <= 1'b1;
    end
  end

  cipher_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_word),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level)
  );

  assign word_valid      = !fifo_empty;
  assign word_data       = fifo_empty ? 32'h0 : head.data;
  assign word_byte_count = fifo_empty ? 3'd0  : head.byte_count;

endmodule
